// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbiter for four valid/ready channels feeding a single-entry
// registered output stage whose sel register drives the downstream 4:1 mux.
module rr_arb_mux_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic [1:0]   sel,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic [1:0]   last_q, last_d;
    logic [1:0]   sel_q, sel_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;

    logic         load;
    logic         any_valid;
    logic [1:0]   grant;
    logic [W-1:0] grant_data;
    logic         transfer;

    // Scan from last+4 (last itself) down to last+1 so the final hit is the
    // nearest channel after last; the 2-bit sum gives the 3 -> 0 wrap.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign load      = ~out_valid_q | out_ready;
    assign any_valid = |in_valid;
    assign grant     = rr_pick(last_q, in_valid);
    assign transfer  = reset_n & any_valid & load;

    always_comb begin
        unique case (grant)
            2'd0:    grant_data = in_data0;
            2'd1:    grant_data = in_data1;
            2'd2:    grant_data = in_data2;
            default: grant_data = in_data3;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        in_ready = '0;
        if (transfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        last_d      = last_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (transfer) begin
            last_d      = grant;
            sel_d       = grant;
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples its _d value from before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q      <= 2'd3;
            sel_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            last_q      <= last_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Randomized and directed bench for rr_arb_mux_4_1 against a transfer-level
// reference model of the rotating-priority arbiter and output stage.
module tb_rr_arb_mux_4_1;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   in_valid;
    logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]   in_ready;
    logic [1:0]   sel;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    always #5 clk = ~clk;

    rr_arb_mux_4_1 #(.W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who was served last, and what the output stage holds.
    int           m_last;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    logic [3:0]   exp_ready;
    logic [W-1:0] dat [4];

    function automatic int ref_grant();
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_last  = 3;
        m_valid = 0;
        m_data  = '0;
        m_sel   = 0;
    endfunction

    // Called just after a falling edge: drive inputs, then predict in_ready.
    task automatic apply(input logic [3:0] v, input logic ordy);
        int g;
        in_valid  = v;
        in_data0  = dat[0];
        in_data1  = dat[1];
        in_data2  = dat[2];
        in_data3  = dat[3];
        out_ready = ordy;
        #1;
        g = ref_grant();
        if (reset_n && g >= 0 && (!m_valid || out_ready)) exp_ready = 4'(1 << g);
        else exp_ready = 4'b0000;
    endtask

    // Advance one rising edge, update the model, return at the next falling edge.
    task automatic step();
        int g;
        @(posedge clk);
        g = ref_grant();
        if (g >= 0 && (!m_valid || out_ready)) begin
            m_data  = dat[g];
            m_sel   = g;
            m_valid = 1;
            m_last  = g;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        dat[0] = 4'ha; dat[1] = 4'hb; dat[2] = 4'hc; dat[3] = 4'hd;
        in_data0 = dat[0]; in_data1 = dat[1]; in_data2 = dat[2]; in_data3 = dat[3];
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || sel !== 2'd0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%h sel=%0d in_ready=%b, want 0 0 0 0000",
                     out_valid, out_data, sel, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_rotation();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply(4'hF, 1'b1);
            checks++;
            if (in_ready !== exp_ready || in_ready !== 4'(1 << (i % 4))) begin
                errors++;
                $display("FAIL rotation_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << (i % 4)));
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || sel !== 2'(i % 4) || out_data !== 4'(4'ha + 4'(i % 4))) begin
                errors++;
                $display("FAIL rotation_out[%0d]: got valid=%b data=%h sel=%0d want 1 %h %0d",
                         i, out_valid, out_data, sel, 4'(4'ha + 4'(i % 4)), i % 4);
            end
        end
    endtask

    task automatic test_sparse();
        logic [3:0] want_ready [3];
        logic [W-1:0] want_data [3];
        want_ready = '{4'b0010, 4'b1000, 4'b0010};
        want_data  = '{4'h7, 4'h3, 4'h7};
        dat[1] = 4'h7;
        dat[3] = 4'h3;
        for (int i = 0; i < 3; i++) begin
            apply(4'b1010, 1'b1);
            checks++;
            if (in_ready !== want_ready[i] || in_ready !== exp_ready) begin
                errors++;
                $display("FAIL sparse_ready[%0d]: got %b want %b", i, in_ready, want_ready[i]);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== want_data[i] || sel !== 2'(m_sel)) begin
                errors++;
                $display("FAIL sparse_out[%0d]: got data=%h sel=%0d want %h %0d",
                         i, out_data, sel, want_data[i], m_sel);
            end
        end
    endtask

    task automatic test_backpressure();
        dat[2] = 4'hc;
        dat[3] = 4'hd;
        apply(4'b0100, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hc || sel !== 2'd2) begin
            errors++;
            $display("FAIL bp_load: got data=%h sel=%0d valid=%b want c 2 1", out_data, sel, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            apply(4'hF, 1'b0);
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'hc || sel !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got data=%h sel=%0d valid=%b want c 2 1",
                         i, out_data, sel, out_valid);
            end
        end
        apply(4'hF, 1'b1);
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 1000", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hd || sel !== 2'd3) begin
            errors++;
            $display("FAIL bp_release_out: got data=%h sel=%0d want d 3", out_data, sel);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] reqs [3];
        logic [1:0] want [3];
        reqs = '{4'b0001, 4'b1000, 4'b1001};
        want = '{2'd0, 2'd3, 2'd0};
        for (int i = 0; i < 3; i++) begin
            apply(reqs[i], 1'b1);
            checks++;
            if (in_ready !== 4'(1 << want[i])) begin
                errors++;
                $display("FAIL wrap_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << want[i]));
            end
            step();
            checks++;
            if (sel !== want[i] || out_data !== dat[want[i]] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap_out[%0d]: got sel=%0d data=%h want %0d %h",
                         i, sel, out_data, want[i], dat[want[i]]);
            end
        end
    endtask

    task automatic test_drain();
        dat[1] = 4'hb;
        apply(4'b0010, 1'b1);
        step();
        apply(4'b0000, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'hb || sel !== 2'd1) begin
            errors++;
            $display("FAIL drain: got valid=%b data=%h sel=%0d want 0 b 1", out_valid, out_data, sel);
        end
    endtask

    task automatic test_async_reset();
        apply(4'b0010, 1'b1);
        step();
        apply(4'b0000, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || sel !== 2'd0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%h sel=%0d in_ready=%b want 0 0 0 0000",
                     out_valid, out_data, sel, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        apply(4'b0101, 1'b1);
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 0001", in_ready);
        end
        step();
        checks++;
        if (sel !== 2'd0 || out_data !== dat[0] || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_out: got sel=%0d data=%h want 0 %h", sel, out_data, dat[0]);
        end
    endtask

    task automatic test_random();
        logic [3:0] pending;
        logic [3:0] accepted;
        pending = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 4; c++) begin
                if (!pending[c] && ($urandom % 2 == 0)) begin
                    pending[c] = 1'b1;
                    dat[c]     = W'($urandom);
                end
            end
            apply(pending, ($urandom % 4) != 0);
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, exp_ready);
            end
            accepted = exp_ready;
            step();
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || sel !== 2'(m_sel)) begin
                errors++;
                $display("FAIL rand_out[%0d]: got valid=%b data=%h sel=%0d want %b %h %0d",
                         n, out_valid, out_data, sel, m_valid, m_data, m_sel);
            end
            pending = pending & ~accepted;
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_sparse();
        test_backpressure();
        test_wrap();
        test_drain();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
